// File: rtl/cla_subtractor_pipe.sv
// rtl/cla_subtractor_pipe.sv - two-stage pipelined carry-lookahead subtractor
//
// Computes d = a - b - borrow_in as a + ~b + ~borrow_in. Stage 1 resolves the
// low GROUP bits and their group carry. Stage 2 resolves the high WIDTH-GROUP
// bits from the registered raw slices and that carry. Valid/ready on both sides.
// One beat per cycle, two-cycle latency.
//
// Optional feature: define CLA_SUB_OVF_EN to add out_ovf (signed overflow).
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-low reset
//   in_valid    in   operand beat present
//   in_ready    out  stage 1 can accept a beat
//   in_a        in   minuend [WIDTH]
//   in_b        in   subtrahend [WIDTH]
//   in_borrow   in   borrow-in
//   out_valid   out  result beat present
//   out_ready   in   consumer accepts result
//   out_d       out  difference mod 2^WIDTH [WIDTH]
//   out_borrow  out  unsigned borrow-out (a < b + borrow_in)
//   out_ovf     out  signed overflow (CLA_SUB_OVF_EN only)

module cla_subtractor_pipe #(
  parameter int WIDTH = 5,
  parameter int GROUP = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_borrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_borrow
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LO = GROUP;
  localparam int HI = WIDTH - GROUP;

  generate
    if (GROUP < 1 || GROUP >= WIDTH || WIDTH > 64) begin : g_bad_params
      $error("cla_subtractor_pipe: need 1 <= GROUP < WIDTH <= 64");
    end
  endgenerate

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic [LO-1:0] s1_low_q;
  logic          s1_cg_q;
  logic [HI-1:0] s1_hi_a_q;
  logic [HI-1:0] s1_hi_nb_q;
  logic [WIDTH-1:0] out_d_q;
  logic          out_borrow_q;

  logic s2_advance;
  logic in_xfer;
  logic out_xfer;

  assign s2_advance = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | s2_advance;
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = s2_valid_q & out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_xfer)         s1_valid_d = 1'b1;
    else if (s2_advance) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_advance)    s2_valid_d = 1'b1;
    else if (out_xfer) s2_valid_d = 1'b0;
  end

  // Low group: every carry is expanded in lookahead form, i.e. the OR over j
  // of g[j] AND p[j+1..i], plus p[0..i] AND cin. On the last iteration the
  // running term/prop are the group generate/propagate, so lo_c[LO] is c_g.
  logic [LO-1:0] lo_p, lo_g, lo_sum;
  logic [LO:0]   lo_c;
  logic          lo_cin, lo_term, lo_prop;

  always_comb begin
    lo_p    = in_a[LO-1:0] ^ ~in_b[LO-1:0];
    lo_g    = in_a[LO-1:0] & ~in_b[LO-1:0];
    lo_cin  = ~in_borrow;
    lo_term = 1'b0;
    lo_prop = 1'b1;
    lo_c    = '0;
    lo_c[0] = lo_cin;
    for (int i = 0; i < LO; i++) begin
      lo_term = 1'b0;
      lo_prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        lo_term = lo_term | (lo_prop & lo_g[j]);
        lo_prop = lo_prop & lo_p[j];
      end
      lo_c[i+1] = lo_term | (lo_prop & lo_cin);
    end
    lo_sum = lo_p ^ lo_c[LO-1:0];
  end

  // High slice: same lookahead form, seeded by the registered group carry.
  logic [HI-1:0] hi_p, hi_g, hi_sum;
  logic [HI:0]   hi_c;
  logic          hi_term, hi_prop;

  always_comb begin
    hi_p    = s1_hi_a_q ^ s1_hi_nb_q;
    hi_g    = s1_hi_a_q & s1_hi_nb_q;
    hi_term = 1'b0;
    hi_prop = 1'b1;
    hi_c    = '0;
    hi_c[0] = s1_cg_q;
    for (int i = 0; i < HI; i++) begin
      hi_term = 1'b0;
      hi_prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        hi_term = hi_term | (hi_prop & hi_g[j]);
        hi_prop = hi_prop & hi_p[j];
      end
      hi_c[i+1] = hi_term | (hi_prop & s1_cg_q);
    end
    hi_sum = hi_p ^ hi_c[HI-1:0];
  end

`ifdef CLA_SUB_OVF_EN
  // a[MSB] and ~b[MSB] ride through s1 as the top bits of the high slices.
  logic out_ovf_q;
  logic ovf_d;
  assign ovf_d   = (s1_hi_a_q[HI-1] ^ ~s1_hi_nb_q[HI-1]) &
                   (s1_hi_a_q[HI-1] ^ hi_sum[HI-1]);
  assign out_ovf = out_ovf_q;

  always_ff @(posedge clock) begin
    if (!reset)          out_ovf_q <= 1'b0;
    else if (s2_advance) out_ovf_q <= ovf_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_low_q     <= '0;
      s1_cg_q      <= 1'b0;
      s1_hi_a_q    <= '0;
      s1_hi_nb_q   <= '0;
      out_d_q      <= '0;
      out_borrow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_xfer) begin
        s1_low_q   <= lo_sum;
        s1_cg_q    <= lo_c[LO];
        s1_hi_a_q  <= in_a[WIDTH-1:LO];
        s1_hi_nb_q <= ~in_b[WIDTH-1:LO];
      end
      if (s2_advance) begin
        out_d_q      <= {hi_sum, s1_low_q};
        out_borrow_q <= ~hi_c[HI];
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_d      = out_d_q;
  assign out_borrow = out_borrow_q;

endmodule
